// File: rtl/key_exp_inv.sv
// Inverse AES-128 key-expansion step: rebuilds round key i-1 from round key i, bytes row-major.
// Column 0 needs SubWord(RotWord(col 3)) via an external S-box with one-cycle read latency.
module key_exp_inv #(
  parameter logic [7:0] RCON = 8'h02
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       enable_din,
  output logic [7:0] addr_out,
  output logic       enable_sbox,
  input  logic [7:0] sbox_in,
  input  logic       round_complete,
  output logic [7:0] dout,
  output logic       enable_out
);

  typedef enum logic [2:0] {LOAD, UNXOR, SUB, XOR0, WAIT, OUT} state_t;

  state_t     state, next_state;
  logic [3:0] cnt;
  logic [7:0] k [16];
  logic [7:0] p [16];
  logic [7:0] s [4];
  logic [7:0] addr_hold, dout_hold;
  logic [1:0] col, col_prev, s_idx;
  logic [3:0] sub_idx;

  // UNXOR walks columns 3,2,1; SUB addresses bytes 7,11,15,3 (RotWord of column 3)
  // and captures each S-box result one cycle later into s[cnt-1].
  always_comb begin
    col      = 2'd3 - cnt[1:0];
    col_prev = col - 2'd1;
    s_idx    = cnt[1:0] - 2'd1;
    sub_idx  = {cnt[1:0] + 2'd1, 2'd3};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      LOAD:    if (enable_din && cnt == 4'd15) next_state = UNXOR;
      UNXOR:   if (cnt == 4'd2)  next_state = SUB;
      SUB:     if (cnt == 4'd4)  next_state = XOR0;
      XOR0:    next_state = WAIT;
      WAIT:    if (round_complete) next_state = OUT;
      OUT:     if (cnt == 4'd15) next_state = LOAD;
      default: next_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else begin
      case (state)
        LOAD:           if (enable_din) cnt <= cnt + 4'd1;
        UNXOR, SUB, OUT: cnt <= cnt + 4'd1;
        default:        cnt <= '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && enable_din) k[cnt] <= din;
    if (state == UNXOR) begin
      p[{2'd0, col}] <= k[{2'd0, col}] ^ k[{2'd0, col_prev}];
      p[{2'd1, col}] <= k[{2'd1, col}] ^ k[{2'd1, col_prev}];
      p[{2'd2, col}] <= k[{2'd2, col}] ^ k[{2'd2, col_prev}];
      p[{2'd3, col}] <= k[{2'd3, col}] ^ k[{2'd3, col_prev}];
    end
    if (state == SUB && cnt != 4'd0) s[s_idx] <= sbox_in;
    if (state == XOR0) begin
      p[0]  <= k[0]  ^ s[0] ^ RCON;
      p[4]  <= k[4]  ^ s[1];
      p[8]  <= k[8]  ^ s[2];
      p[12] <= k[12] ^ s[3];
    end
  end

  // Unqualified outputs keep showing the last qualified value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hold <= '0;
      dout_hold <= '0;
    end else begin
      if (enable_sbox) addr_hold <= p[sub_idx];
      if (enable_out)  dout_hold <= p[cnt];
    end
  end

  always_comb begin
    enable_sbox = (state == SUB) && (cnt < 4'd4);
    enable_out  = (state == OUT);
    addr_out    = enable_sbox ? p[sub_idx] : addr_hold;
    dout        = enable_out ? p[cnt] : dout_hold;
  end

endmodule

// File: tb/tb_key_exp_inv.sv
// Directed bench for key_exp_inv: FIPS-197 round keys 2->1->0 through two instances (RCON 01 and 02).
module tb_key_exp_inv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       enable_din;
  logic       round_complete;
  logic [7:0] addr1, addr2, sbox1, sbox2, dout1, dout2;
  logic       esb1, esb2, eo1, eo2;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K0 = 128'h2b28ab09_7eaef7cf_15d2154f_16a6883c;
  localparam logic [127:0] K1 = 128'ha088232a_fa54a36c_fe2c3976_17b13905;
  localparam logic [127:0] K2 = 128'hf27a5973_c2963559_95b980f6_f2437a7f;
  localparam logic [31:0]  A1 = 32'hcf4f3c09;
  localparam logic [31:0]  A2 = 32'h6c76052a;

  always #5 clk = ~clk;

  key_exp_inv #(.RCON(8'h01)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .din(din), .enable_din(enable_din),
    .addr_out(addr1), .enable_sbox(esb1), .sbox_in(sbox1),
    .round_complete(round_complete), .dout(dout1), .enable_out(eo1)
  );

  key_exp_inv #(.RCON(8'h02)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .din(din), .enable_din(enable_din),
    .addr_out(addr2), .enable_sbox(esb2), .sbox_in(sbox2),
    .round_complete(round_complete), .dout(dout2), .enable_out(eo2)
  );

  // AES S-box entries reached by the vectors below.
  function automatic logic [7:0] sbox_f(input logic [7:0] a);
    case (a)
      8'hcf:   return 8'h8a;
      8'h4f:   return 8'h84;
      8'h3c:   return 8'heb;
      8'h09:   return 8'h01;
      8'h6c:   return 8'h50;
      8'h76:   return 8'h38;
      8'h05:   return 8'h6b;
      8'h2a:   return 8'he5;
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk) begin
    sbox1 <= sbox_f(addr1);
    sbox2 <= sbox_f(addr2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_key(input logic [127:0] key, input bit gaps);
    for (int n = 0; n < 16; n++) begin
      if (gaps) begin
        enable_din = 1'b0;
        din        = 8'hee;
        @(negedge clk);
      end
      enable_din = 1'b1;
      din        = key[127-8*n -: 8];
      @(negedge clk);
    end
    enable_din = 1'b0;
    din        = 8'h00;
  endtask

  // Called at the negedge of the first cycle after the last key byte. With round_complete
  // high, the ten cycles UNXOR(3) + SUB(5) + XOR0(1) + WAIT(1) pass before the first dout.
  task automatic run_round(input string tag, input bit use2, input logic [127:0] exp_dout,
                           input logic [31:0] exp_addr, input int hold, input bit noise);
    int cyc = 0;
    int nsb = 0;
    int nout = 0;
    int first = 0;
    int last = 0;
    logic sb, eo;
    logic [7:0] ad, dq;
    while (nout < 16 && cyc < 200) begin
      cyc++;
      sb = use2 ? esb2 : esb1;
      eo = use2 ? eo2 : eo1;
      ad = use2 ? addr2 : addr1;
      dq = use2 ? dout2 : dout1;
      if (sb) begin
        if (nsb < 4) check($sformatf("%s addr%0d", tag, nsb), 32'(ad), 32'(exp_addr[31-8*nsb -: 8]));
        nsb++;
      end
      if (eo) begin
        if (nout == 0) first = cyc;
        last = cyc;
        check($sformatf("%s dout%0d", tag, nout), 32'(dq), 32'(exp_dout[127-8*nout -: 8]));
        nout++;
      end
      round_complete = (hold == 0) || (cyc >= 10 + hold);
      if (noise) begin
        enable_din = 1'b1;
        din        = 8'($urandom);
      end
      @(negedge clk);
    end
    enable_din = 1'b0;
    din        = 8'h00;
    check({tag, " sbox_count"}, 32'(nsb), 32'd4);
    check({tag, " out_count"}, 32'(nout), 32'd16);
    check({tag, " first_out_cycle"}, 32'(first), 32'(11 + hold));
    check({tag, " out_span"}, 32'(last - first), 32'd15);
    check({tag, " out_low_after"}, 32'(use2 ? eo2 : eo1), 32'd0);
    check({tag, " dout_hold"}, 32'(use2 ? dout2 : dout1), 32'(exp_dout[7:0]));
  endtask

  initial begin
    bit found;
    int nsb;

    rst_n          = 1'b0;
    din            = 8'h00;
    enable_din     = 1'b0;
    round_complete = 1'b1;
    #2;
    check("reset enable_sbox", 32'(esb1), 32'd0);
    check("reset enable_out", 32'(eo1), 32'd0);
    check("reset addr_out", 32'(addr1), 32'd0);
    check("reset dout", 32'(dout1), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Partial garbage key, then reset: the next load must start at byte 0.
    for (int n = 0; n < 7; n++) begin
      enable_din = 1'b1;
      din        = 8'(8'h30 + n);
      @(negedge clk);
    end
    enable_din = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    load_key(K1, 1'b0);
    run_round("k1_rcon01", 1'b0, K0, A1, 0, 1'b0);

    load_key(K2, 1'b0);
    run_round("k2_rcon02", 1'b1, K1, A2, 0, 1'b0);

    load_key(K1, 1'b1);
    run_round("k1_gaps_noise", 1'b0, K0, A1, 0, 1'b1);

    load_key(K1, 1'b0);
    run_round("k1_wait50", 1'b0, K0, A1, 50, 1'b0);
    load_key(K2, 1'b0);
    run_round("k2_after_wait", 1'b1, K1, A2, 0, 1'b0);

    // Reset while the second S-box address is on the bus.
    load_key(K1, 1'b0);
    found = 1'b0;
    nsb   = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      if (esb1) begin
        nsb++;
        if (nsb == 2) found = 1'b1;
      end
      if (!found) @(negedge clk);
    end
    check("sub_second_addr_seen", 32'(found), 32'd1);
    check("sub_second_addr", 32'(addr1), 32'h4f);
    rst_n = 1'b0;
    #1;
    check("midsub_reset enable_sbox", 32'(esb1), 32'd0);
    check("midsub_reset addr_out", 32'(addr1), 32'd0);
    check("midsub_reset enable_out", 32'(eo1), 32'd0);
    check("midsub_reset dout", 32'(dout1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    load_key(K1, 1'b0);
    run_round("k1_after_reset", 1'b0, K0, A1, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
